// File: rtl/mem_dma.sv
// Block-copy / fill initiator for the 256x8 synchronous-read RAM port.
// Honours the one-cycle read latency by alternating read and write cycles during a copy.
module mem_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_fill,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_enable,
    input  logic [DATA_W-1:0] i_mem_data_read
);

    // state | meaning
    // IDLE  | waiting for i_start; CPU owns the RAM port
    // RD    | copy: present src+k, data returns next cycle
    // WR    | copy: write returned byte to dst+k
    // FILL  | fill: write fill byte to dst+k
    // DONE  | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_FILL,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] fill_q;
    logic [ADDR_W:0]   k_q;
    logic [ADDR_W:0]   k_inc;
    logic              last;

    assign k_inc = k_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last  = (k_inc == len_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_start) begin
                src_q  <= i_src;
                dst_q  <= i_dst;
                len_q  <= i_len;
                fill_q <= i_fill;
                k_q    <= '0;
            end else if (state_q == S_WR || state_q == S_FILL) begin
                k_q <= k_inc;
            end
        end
    end

    // Address sums drop the carry so both bases wrap modulo the RAM size.
    always_comb begin
        state_d            = state_q;
        o_busy             = 1'b0;
        o_done             = 1'b0;
        o_mem_addr         = '0;
        o_mem_data_write   = '0;
        o_mem_write_enable = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len == '0)
                        state_d = S_DONE;
                    else if (i_mode)
                        state_d = S_FILL;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                o_busy     = 1'b1;
                o_mem_addr = src_q + k_q[ADDR_W-1:0];
                state_d    = S_WR;
            end
            S_WR: begin
                o_busy             = 1'b1;
                o_mem_addr         = dst_q + k_q[ADDR_W-1:0];
                o_mem_data_write   = i_mem_data_read;
                o_mem_write_enable = 1'b1;
                state_d            = last ? S_DONE : S_RD;
            end
            S_FILL: begin
                o_busy             = 1'b1;
                o_mem_addr         = dst_q + k_q[ADDR_W-1:0];
                o_mem_data_write   = fill_q;
                o_mem_write_enable = 1'b1;
                state_d            = last ? S_DONE : S_FILL;
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: behavioural RAM with CPU/DMA port mux, and a byte-level model of each command.
module tb_mem_dma;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic       i_mode;
    logic [7:0] i_src;
    logic [7:0] i_dst;
    logic [8:0] i_len;
    logic [7:0] i_fill;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_data_write;
    logic       o_mem_write_enable;
    logic [7:0] i_mem_data_read;

    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [7:0] ram [256];
    logic [7:0] model [256];

    int checks = 0;
    int errors = 0;

    mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_mode             (i_mode),
        .i_src              (i_src),
        .i_dst              (i_dst),
        .i_len              (i_len),
        .i_fill             (i_fill),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_mem_addr         (o_mem_addr),
        .o_mem_data_write   (o_mem_data_write),
        .o_mem_write_enable (o_mem_write_enable),
        .i_mem_data_read    (i_mem_data_read)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM port belongs to the DMA while it is busy, otherwise to the CPU side.
    assign ram_addr  = o_busy ? o_mem_addr         : cpu_addr;
    assign ram_wdata = o_busy ? o_mem_data_write   : cpu_wdata;
    assign ram_we    = o_busy ? o_mem_write_enable : cpu_we;

    // Registered read, read-before-write.
    always @(posedge i_clk) begin
        i_mem_data_read <= ram[ram_addr];
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_we"},   32'(o_mem_write_enable), 0);
        chk({tag, "_addr"}, 32'(o_mem_addr), 0);
        chk({tag, "_data"}, 32'(o_mem_data_write), 0);
    endtask

    task automatic chk_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== model[i]) bad++;
        chk({tag, "_mem_bad_bytes"}, 32'(bad), 0);
    endtask

    task automatic cpu_write(input int a, input int d);
        cpu_addr  = a[7:0];
        cpu_wdata = d[7:0];
        cpu_we    = 1'b1;
        @(negedge i_clk);
        cpu_we    = 1'b0;
        model[a & 255] = d[7:0];
    endtask

    // Called at a negedge in IDLE. rst_at/poke_at: busy-cycle index for reset / stray start (0 = none).
    task automatic run_cmd(input string tag, input int mode, input int src, input int dst,
                           input int len, input int fill, input int rst_at, input int poke_at);
        int nbusy, k, a, v;
        bit wr;
        i_mode  = mode[0];
        i_src   = src[7:0];
        i_dst   = dst[7:0];
        i_len   = len[8:0];
        i_fill  = fill[7:0];
        i_start = 1'b1;
        nbusy   = (len == 0) ? 0 : (mode != 0 ? len : 2 * len);
        @(negedge i_clk);
        i_start = 1'b0;
        i_src   = 8'($urandom);
        i_dst   = 8'($urandom);
        i_len   = 9'($urandom);
        i_fill  = 8'($urandom);
        i_mode  = 1'($urandom);
        for (int c = 1; c <= nbusy; c++) begin
            if (mode != 0) begin
                k  = c - 1;
                wr = 1'b1;
            end else begin
                k  = (c - 1) / 2;
                wr = (c % 2 == 0);
            end
            chk({tag, "_busy"}, 32'(o_busy), 1);
            chk({tag, "_done_early"}, 32'(o_done), 0);
            chk({tag, "_we"}, 32'(o_mem_write_enable), 32'(wr));
            if (wr) begin
                a = (dst + k) & 255;
                v = (mode != 0) ? (fill & 255) : int'(model[(src + k) & 255]);
                chk({tag, "_waddr"}, 32'(o_mem_addr), a);
                chk({tag, "_wdata"}, 32'(o_mem_data_write), v);
                model[a] = v[7:0];
            end else begin
                chk({tag, "_raddr"}, 32'(o_mem_addr), (src + k) & 255);
            end
            if (c == poke_at) begin
                i_start = 1'b1;
                i_mode  = 1'b1;
                i_len   = 9'd3;
            end
            if (c == rst_at) i_rst = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
            if (c == rst_at) begin
                i_rst = 1'b0;
                chk({tag, "_rst_done"}, 32'(o_done), 0);
                chk_idle({tag, "_rst"});
                @(negedge i_clk);
                chk({tag, "_rst_done2"}, 32'(o_done), 0);
                chk_idle({tag, "_rst2"});
                chk_mem(tag);
                return;
            end
        end
        chk({tag, "_done"}, 32'(o_done), 1);
        chk_idle({tag, "_donecyc"});
        @(negedge i_clk);
        chk({tag, "_done_once"}, 32'(o_done), 0);
        chk_idle({tag, "_after"});
        chk_mem(tag);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_start   = 1'b0;
        i_mode    = 1'b0;
        i_src     = '0;
        i_dst     = '0;
        i_len     = '0;
        i_fill    = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_done", 32'(o_done), 0);
        chk_idle("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < 256; i++) cpu_write(i, int'($urandom_range(0, 255)));

        run_cmd("fill4", 1, 0, 8'h20, 4, 8'hA5, 0, 0);
        for (int i = 0; i < 4; i++) chk("fill4_byte", 32'(ram[8'h20 + i]), 32'hA5);

        cpu_write(0, 8'h19); cpu_write(1, 8'h01); cpu_write(2, 8'h50); cpu_write(3, 8'h21);
        run_cmd("copy4", 0, 8'h00, 8'h40, 4, 0, 0, 0);
        chk("copy4_b0", 32'(ram[8'h40]), 32'h19);
        chk("copy4_b3", 32'(ram[8'h43]), 32'h21);

        cpu_write(8'hFE, 8'h11); cpu_write(8'hFF, 8'h22); cpu_write(0, 8'h33); cpu_write(1, 8'h44);
        run_cmd("wrap", 0, 8'hFE, 8'h01, 4, 0, 0, 0);
        chk("wrap_b1", 32'(ram[1]), 32'h11);
        chk("wrap_b3", 32'(ram[3]), 32'h33);
        chk("wrap_b4", 32'(ram[4]), 32'h11);

        cpu_write(8'h10, 8'h7E);
        run_cmd("repl", 0, 8'h10, 8'h11, 3, 0, 0, 0);
        chk("repl_b13", 32'(ram[8'h13]), 32'h7E);

        run_cmd("len0", 1, 0, 8'h55, 0, 8'hFF, 0, 0);
        run_cmd("fill256", 1, 0, 8'h9C, 256, 8'h00, 0, 0);
        for (int i = 0; i < 256; i++) cpu_write(i, int'($urandom_range(0, 255)));
        run_cmd("copy256", 0, 8'h37, 8'hC1, 256, 0, 0, 0);

        run_cmd("poke", 0, 8'h80, 8'h90, 5, 0, 0, 4);
        run_cmd("rst_mid", 1, 0, 8'h60, 8, 8'h3C, 3, 0);
        chk("rst_mid_b2", 32'(ram[8'h62]), 32'h3C);
        run_cmd("after_rst", 1, 0, 8'h60, 8, 8'hC3, 0, 0);

        i_rst   = 1'b1;
        i_start = 1'b1;
        i_mode  = 1'b1;
        i_len   = 9'd5;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_start = 1'b0;
        chk("rst_prio_done", 32'(o_done), 0);
        chk_idle("rst_prio");
        @(negedge i_clk);
        chk("rst_prio_done2", 32'(o_done), 0);
        chk_idle("rst_prio2");

        for (int n = 0; n < 12; n++) begin
            run_cmd("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 24)),
                    int'($urandom_range(0, 255)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
